// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if: configuration handshake bundle for clk_en_gen.
//   master : drives cfg_valid, cfg_ch, cfg_div, cfg_phase; samples cfg_ready
//   slave  : samples the request fields; drives cfg_ready
// Parameters NUM_CH and DIV_W must match the clk_en_gen instance.
interface clk_en_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator with lock timing and
// power-down. Each channel emits a one-cycle strobe every (div+1) cycles at
// offset min(phase, div). Accepted configuration restarts lock and realigns
// every channel to a common zero.
//
// Ports:
//   clk     : sole clock
//   rst_n   : asynchronous active-low reset
//   pwrdwn  : level-sensitive power-down request
//   cfg     : clk_en_gen_if.slave (cfg_valid/cfg_ready/cfg_ch/cfg_div/cfg_phase)
//   ce      : registered per-channel enable strobes
//   locked  : registered lock indication
//
// Build option: define CLK_EN_GEN_GATE_EN to suppress ce while locked is low.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_PWRDN   | powered down: counters held 0, ce=0, locked=0
// ST_LOCKING | lock_cnt running toward LOCK_CYCLES-1, channels running
// ST_LOCKED  | lock achieved, locked=1, channels running
module clk_en_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwrdwn,
    clk_en_gen_if.slave       cfg,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);
    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_PWRDN   = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic [LCK_W-1:0] lock_cnt;
    logic [DIV_W-1:0] cnt   [NUM_CH];
    logic [DIV_W-1:0] div   [NUM_CH];
    logic [DIV_W-1:0] phase [NUM_CH];
    logic [DIV_W-1:0] eff_ph[NUM_CH];
    logic [NUM_CH-1:0] match;
    logic             accept;
    logic             ch_ok;
    logic             lock_last;

    assign cfg.cfg_ready = ~pwrdwn;
    assign accept        = cfg.cfg_valid & ~pwrdwn;
    // Out-of-range channel requests complete the handshake but are dropped.
    assign ch_ok         = (int'(cfg.cfg_ch) < NUM_CH);
    assign lock_last     = (lock_cnt == LCK_W'(LOCK_CYCLES - 1));

    // Phase beyond the period is clamped to the last count of the period.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eff_ph[i] = (phase[i] > div[i]) ? div[i] : phase[i];
            match[i]  = (cnt[i] == eff_ph[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOCKING;
            lock_cnt <= '0;
            ce       <= '0;
            locked   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                div[i]   <= DIV_W'(DEFAULT_DIV);
                phase[i] <= '0;
            end
        end else if (pwrdwn) begin
            state    <= ST_PWRDN;
            lock_cnt <= '0;
            ce       <= '0;
            locked   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if ((state == ST_PWRDN) || (accept && ch_ok)) begin
            // Restart: the next cycle is LOCKING cycle 0 with all counters at 0.
            if (accept && ch_ok) begin
                div[cfg.cfg_ch]   <= cfg.cfg_div;
                phase[cfg.cfg_ch] <= cfg.cfg_phase;
            end
            state    <= ST_LOCKING;
            lock_cnt <= '0;
            ce       <= '0;
            locked   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= (cnt[i] == div[i]) ? '0 : cnt[i] + DIV_W'(1);
`ifdef CLK_EN_GEN_GATE_EN
            // Gate with the lock value being registered on this same edge.
            ce <= match & {NUM_CH{(state == ST_LOCKED) || lock_last}};
`else
            ce <= match;
`endif
            if (state == ST_LOCKING) begin
                if (lock_last) begin
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + LCK_W'(1);
                end
            end else begin
                locked <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;
    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 1;
    localparam int LOCK_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pwrdwn;
    logic [NUM_CH-1:0] ce;
    logic              locked;

    int total = 0;
    int bad   = 0;

    clk_en_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_en_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwrdwn(pwrdwn),
        .cfg(cfg_if.slave), .ce(ce), .locked(locked)
    );

    always #5 clk = ~clk;

    // Reference model: t = cycles since the last restart; strobes and lock
    // follow directly from t with plain arithmetic.
    typedef struct packed {
        logic [NUM_CH-1:0] ce;
        logic              locked;
    } exp_t;

    exp_t exp_q[$];
    int   m_div[NUM_CH];
    int   m_ph [NUM_CH];
    int   m_t;
    bit   m_off;

    function automatic exp_t predict(int t, bit off);
        exp_t e;
        e = '0;
        if (!off) begin
            e.locked = (t >= LOCK_CYCLES);
            for (int i = 0; i < NUM_CH; i++) begin
                int d, p;
                d = m_div[i];
                p = (m_ph[i] < d) ? m_ph[i] : d;
                if ((t - 1 >= p) && (((t - 1 - p) % (d + 1)) == 0))
                    e.ce[i] = 1'b1;
            end
`ifdef CLK_EN_GEN_GATE_EN
            if (!e.locked) e.ce = '0;
`endif
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = DEFAULT_DIV;
                m_ph[i]  = 0;
            end
            m_t   = 0;
            m_off = 1'b0;
        end else begin
            total++;
            if (cfg_if.cfg_ready !== !pwrdwn) begin
                bad++;
                $display("FAIL cfg_ready: got %b want %b at %0t", cfg_if.cfg_ready, !pwrdwn, $time);
            end
            if (pwrdwn) begin
                m_off = 1'b1;
                m_t   = 0;
            end else if (m_off || (cfg_if.cfg_valid && int'(cfg_if.cfg_ch) < NUM_CH)) begin
                if (cfg_if.cfg_valid && int'(cfg_if.cfg_ch) < NUM_CH) begin
                    m_div[cfg_if.cfg_ch] = int'(cfg_if.cfg_div);
                    m_ph[cfg_if.cfg_ch]  = int'(cfg_if.cfg_phase);
                end
                m_off = 1'b0;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end
        exp_q.push_back(predict(m_t, m_off));
    end

    // Monitor: one output word per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue: empty, got ce=%b locked=%b at %0t", ce, locked, $time);
            end else begin
                e = exp_q.pop_front();
                if (!rst_n) e = '0;
                total += 2;
                if (ce !== e.ce) begin
                    bad++;
                    $display("FAIL ce: got %b want %b at %0t", ce, e.ce, $time);
                end
                if (locked !== e.locked) begin
                    bad++;
                    $display("FAIL locked: got %b want %b at %0t", locked, e.locked, $time);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(int ch, int dv, int ph);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch[cfg_if.CH_W-1:0];
        cfg_if.cfg_div   = dv[DIV_W-1:0];
        cfg_if.cfg_phase = ph[DIV_W-1:0];
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        pwrdwn           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_phase = '0;
        tick(3);
        rst_n = 1'b1;
        tick(40);                 // default div, lock at cycle 16

        cfg_write(2, 4, 2);       // ce[2] at 3,8,13
        tick(30);
        cfg_write(1, 3, 9);       // clamped phase
        tick(30);

        pwrdwn = 1'b1;            // power-down with simultaneous request
        cfg_write(0, 7, 1);
        tick(5);
        pwrdwn = 1'b0;
        tick(25);

        cfg_write(3, 5, 0);       // out-of-range channel: dropped
        tick(10);

        cfg_write(0, 2, 1);       // back-to-back restarts
        cfg_write(1, 5, 3);
        cfg_write(2, 1, 1);
        tick(25);

        cfg_write(0, 0, 0);       // strobe every cycle
        cfg_write(1, 255, 255);   // maximum ratio
        tick(530);

        @(posedge clk);           // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(30);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) pwrdwn = ~pwrdwn;
            if ($urandom_range(0, 14) == 0) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
                cfg_if.cfg_div   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
                cfg_if.cfg_phase = 8'($urandom_range(0, 16));
            end else begin
                cfg_if.cfg_valid = 1'b0;
            end
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        pwrdwn           = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
